// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and constants for the register-file write arbiter.
//   state_e        IDLE / CLEAR controller states
//   CLIENT0/1      client identifiers used as grant ids and last_grant values
//   RF_W/RF_N/RF_AW default data width, register count, address width
package rf_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  localparam int RF_W  = 8;
  localparam int RF_N  = 8;
  localparam int RF_AW = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
//   req0_i, req1_i  eligible requests
//   last_grant_i    client granted most recently
//   gnt_valid_o     some request is eligible
//   gnt_id_o        chosen client (the one not granted last on a tie)
module rr_arbiter2
  import rf_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_id_o    = CLIENT0;
    if (req0_i && req1_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (req1_i) begin
      gnt_id_o = CLIENT1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: owns the single write port of the register file, shares
// it between the CPU writeback path (client 0) and the debug/load port
// (client 1), and runs a hardware clear walk that zeroes every register.
//
// Ports:
//   CLK, RESET               clock, async active-low reset
//   REQx/ADDRx/DATAx, ACKx   client request, target, data; one-cycle ack
//   CLEAR_REQ                starts a clear walk when seen in IDLE
//   CLEAR_DONE, BUSY         walk finished pulse; walk in progress
//   RF_WRITE/RF_ADDR/RF_DATA register file WRITE/INADDRESS/IN
//   WPMASK, ERR1             only with RF_WRITE_PROTECT_EN: per-register
//                            protection against client 1, error pulse
//
// Optional feature macro: RF_WRITE_PROTECT_EN.
//
// state | meaning
// IDLE  | arbitrate client requests, accept CLEAR_REQ
// CLEAR | write zero to register cnt_q each cycle, clients held off
module reg_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int W  = RF_W,
  parameter int N  = RF_N,
  parameter int AW = RF_AW   // must equal clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic [AW-1:0] ADDR0,
  input  logic [W-1:0]  DATA0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic [AW-1:0] ADDR1,
  input  logic [W-1:0]  DATA1,
  output logic          ACK1,
  input  logic          CLEAR_REQ,
`ifdef RF_WRITE_PROTECT_EN
  input  logic [N-1:0]  WPMASK,
  output logic          ERR1,
`endif
  output logic          CLEAR_DONE,
  output logic          BUSY,
  output logic          RF_WRITE,
  output logic [AW-1:0] RF_ADDR,
  output logic [W-1:0]  RF_DATA
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef RF_WRITE_PROTECT_EN
  logic          err1_q, err1_d;
`endif

  logic elig0, elig1, gnt_valid, gnt_id;

  // A client whose ack is showing is still holding REQ from the write just
  // issued; treating it as eligible would duplicate that write.
  assign elig0 = REQ0 & ~ack0_q;
  assign elig1 = REQ1 & ~ack1_q;

  rr_arbiter2 u_rr (
    .req0_i       (elig0),
    .req1_i       (elig1),
    .last_grant_i (last_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = 1'b0;
`ifdef RF_WRITE_PROTECT_EN
    err1_d  = 1'b0;
`endif
    // busy_q only rises on clear writes, so busy_q seen back in IDLE means
    // the last clear write was the previous cycle.
    done_d  = busy_q && (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (CLEAR_REQ) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (gnt_valid) begin
          last_d  = gnt_id;
          write_d = 1'b1;
          if (gnt_id == CLIENT0) begin
            addr_d = ADDR0;
            data_d = DATA0;
            ack0_d = 1'b1;
          end else begin
            addr_d = ADDR1;
            data_d = DATA1;
            ack1_d = 1'b1;
`ifdef RF_WRITE_PROTECT_EN
            if (WPMASK[ADDR1]) begin
              write_d = 1'b0;
              err1_d  = 1'b1;
            end
`endif
          end
        end
      end
      CLEAR: begin
        write_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = '0;
        busy_d  = 1'b1;
        if (cnt_q == AW'(N - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= CLIENT1;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RF_WRITE_PROTECT_EN
      err1_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RF_WRITE_PROTECT_EN
      err1_q  <= err1_d;
`endif
    end
  end

  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign CLEAR_DONE = done_q;
  assign BUSY       = busy_q;
  assign RF_WRITE   = write_q;
  assign RF_ADDR    = addr_q;
  assign RF_DATA    = data_q;
`ifdef RF_WRITE_PROTECT_EN
  assign ERR1       = err1_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, CLEAR_REQ = 1'b0;
  logic [2:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] DATA0 = '0, DATA1 = '0;
  logic       ACK0, ACK1, CLEAR_DONE, BUSY, RF_WRITE;
  logic [2:0] RF_ADDR;
  logic [7:0] RF_DATA;
  logic       err1_w;
`ifdef RF_WRITE_PROTECT_EN
  logic [7:0] WPMASK = 8'h00;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic       a0;
    logic       a1;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] rf_mem [8];

  always #5 CLK = ~CLK;

  reg_write_arbiter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ0       (REQ0),
    .ADDR0      (ADDR0),
    .DATA0      (DATA0),
    .ACK0       (ACK0),
    .REQ1       (REQ1),
    .ADDR1      (ADDR1),
    .DATA1      (DATA1),
    .ACK1       (ACK1),
    .CLEAR_REQ  (CLEAR_REQ),
`ifdef RF_WRITE_PROTECT_EN
    .WPMASK     (WPMASK),
    .ERR1       (err1_w),
`endif
    .CLEAR_DONE (CLEAR_DONE),
    .BUSY       (BUSY),
    .RF_WRITE   (RF_WRITE),
    .RF_ADDR    (RF_ADDR),
    .RF_DATA    (RF_DATA)
  );

`ifndef RF_WRITE_PROTECT_EN
  assign err1_w = 1'b0;
`endif

  // Register file behind the write port.
  always @(posedge CLK) begin
    if (RF_WRITE) rf_mem[RF_ADDR] <= RF_DATA;
  end

  // Scoreboard: every active output cycle must match the next expected entry.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET && (RF_WRITE || ACK0 || ACK1 || BUSY || err1_w)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: wr=%0b addr=%0d data=%h ack0=%0b ack1=%0b busy=%0b err1=%0b, nothing expected",
                 RF_WRITE, RF_ADDR, RF_DATA, ACK0, ACK1, BUSY, err1_w);
      end else begin
        e = exp_q.pop_front();
        if ({RF_WRITE, RF_ADDR, RF_DATA, ACK0, ACK1, BUSY, err1_w} !==
            {e.wr, e.addr, e.data, e.a0, e.a1, e.busy, e.err}) begin
          errors++;
          $display("FAIL sb_output: got wr=%0b addr=%0d data=%h ack0=%0b ack1=%0b busy=%0b err1=%0b, want wr=%0b addr=%0d data=%h ack0=%0b ack1=%0b busy=%0b err1=%0b",
                   RF_WRITE, RF_ADDR, RF_DATA, ACK0, ACK1, BUSY, err1_w,
                   e.wr, e.addr, e.data, e.a0, e.a1, e.busy, e.err);
        end
      end
    end
  end

  function automatic exp_t mk(logic wr, logic [2:0] a, logic [7:0] d,
                              logic a0, logic a1, logic b, logic er);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d; e.a0 = a0; e.a1 = a1; e.busy = b; e.err = er;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; CLEAR_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({RF_WRITE, RF_ADDR, RF_DATA, ACK0, ACK1, CLEAR_DONE, BUSY} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%0b addr=%0d data=%h ack0=%0b ack1=%0b done=%0b busy=%0b, want all 0",
               RF_WRITE, RF_ADDR, RF_DATA, ACK0, ACK1, CLEAR_DONE, BUSY);
    end
    RESET = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge CLK);
    REQ0 = 1'b1; ADDR0 = 3'd3; DATA0 = 8'hA5;
    exp_q.push_back(mk(1, 3'd3, 8'hA5, 1, 0, 0, 0));
    @(negedge CLK);
    checks++;
    if (!(RF_WRITE === 1'b1 && ACK0 === 1'b1)) begin
      errors++;
      $display("FAIL single_latency: got wr=%0b ack0=%0b, want wr=1 ack0=1", RF_WRITE, ACK0);
    end
    REQ0 = 1'b0;
    @(negedge CLK);
    checks++;
    if (rf_mem[3] !== 8'hA5) begin
      errors++;
      $display("FAIL single_rf3: got %h, want a5", rf_mem[3]);
    end
    checks++;
    if (RF_WRITE !== 1'b0 || ACK0 !== 1'b0) begin
      errors++;
      $display("FAIL single_no_dup: got wr=%0b ack0=%0b, want 0 0", RF_WRITE, ACK0);
    end
  endtask

  task automatic test_alternate();
    int  n0 = 0, n1 = 0;
    logic p0 = 1'b0, p1 = 1'b0, first = 1'b1;
    do_reset();
    REQ0 = 1'b1; ADDR0 = 3'd1; DATA0 = 8'h10;
    REQ1 = 1'b1; ADDR1 = 3'd2; DATA1 = 8'h20;
    exp_q.push_back(mk(1, 3'd1, 8'h10, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 3'd2, 8'h20, 0, 1, 0, 0));
    exp_q.push_back(mk(1, 3'd1, 8'h11, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 3'd2, 8'h21, 0, 1, 0, 0));
    for (int c = 0; c < 20 && (n0 < 2 || n1 < 2); c++) begin
      @(negedge CLK);
      checks++;
      if ((ACK0 && p0) || (ACK1 && p1)) begin
        errors++;
        $display("FAIL alt_consecutive: ack0=%0b ack1=%0b after ack0=%0b ack1=%0b, want no repeat", ACK0, ACK1, p0, p1);
      end
      if (first && (ACK0 || ACK1)) begin
        first = 1'b0;
        checks++;
        if (ACK0 !== 1'b1) begin
          errors++;
          $display("FAIL alt_first: got ack0=%0b ack1=%0b, want client 0 first", ACK0, ACK1);
        end
      end
      if (ACK0) begin
        n0++;
        if (n0 == 2) REQ0 = 1'b0; else DATA0 = 8'h11;
      end
      if (ACK1) begin
        n1++;
        if (n1 == 2) REQ1 = 1'b0; else DATA1 = 8'h21;
      end
      p0 = ACK0; p1 = ACK1;
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin
      errors++;
      $display("FAIL alt_count: got acks %0d/%0d, want 2/2", n0, n1);
    end
  endtask

  task automatic test_clear();
    int  nbusy = 0, ndone = 0;
    logic got = 1'b0;
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    REQ1 = 1'b1; ADDR1 = 3'd6; DATA1 = 8'h66;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(1, 3'(i), 8'h00, 0, 0, 1, 0));
    exp_q.push_back(mk(1, 3'd6, 8'h66, 0, 1, 0, 0));
    @(negedge CLK);
    CLEAR_REQ = 1'b0;
    checks++;
    if (ACK1 !== 1'b0 || RF_WRITE !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: got ack1=%0b wr=%0b, want 0 0", ACK1, RF_WRITE);
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (BUSY) nbusy++;
      if (CLEAR_DONE) begin
        ndone++;
        checks++;
        if (ACK1 !== 1'b1 || BUSY !== 1'b0) begin
          errors++;
          $display("FAIL clear_done_cycle: got ack1=%0b busy=%0b, want 1 0", ACK1, BUSY);
        end
      end
      if (ACK1) begin
        got = 1'b1;
        REQ1 = 1'b0;
      end
    end
    @(negedge CLK);
    checks++;
    if (nbusy != 8 || ndone != 1 || !got) begin
      errors++;
      $display("FAIL clear_walk: got busy=%0d done=%0d ack=%0b, want 8 1 1", nbusy, ndone, got);
    end
    checks++;
    if (rf_mem[6] !== 8'h66 || rf_mem[1] !== 8'h00 || rf_mem[7] !== 8'h00) begin
      errors++;
      $display("FAIL clear_rf: got r1=%h r6=%h r7=%h, want 00 66 00", rf_mem[1], rf_mem[6], rf_mem[7]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nbusy = 0;
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 3'(i), 8'h00, 0, 0, 1, 0));
    @(negedge CLK);
    CLEAR_REQ = 1'b0;
    for (int c = 0; c < 12 && nbusy < 4; c++) begin
      @(negedge CLK);
      if (BUSY) nbusy++;
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({RF_WRITE, RF_ADDR, RF_DATA, ACK0, ACK1, CLEAR_DONE, BUSY} !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got wr=%0b addr=%0d data=%h busy=%0b done=%0b, want all 0",
               RF_WRITE, RF_ADDR, RF_DATA, BUSY, CLEAR_DONE);
    end
    @(negedge CLK);
    RESET = 1'b1;
    REQ0 = 1'b1; ADDR0 = 3'd4; DATA0 = 8'h44;
    exp_q.push_back(mk(1, 3'd4, 8'h44, 1, 0, 0, 0));
    @(negedge CLK);
    checks++;
    if (ACK0 !== 1'b1 || RF_WRITE !== 1'b1 || CLEAR_DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midreset_grant: got ack0=%0b wr=%0b done=%0b busy=%0b, want 1 1 0 0",
               ACK0, RF_WRITE, CLEAR_DONE, BUSY);
    end
    REQ0 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      checks++;
      if (CLEAR_DONE !== 1'b0) begin
        errors++;
        $display("FAIL midreset_done: got done=%0b, want 0", CLEAR_DONE);
      end
    end
  endtask

  task automatic test_same_addr();
    int  n = 0;
    do_reset();
    REQ0 = 1'b1; ADDR0 = 3'd5; DATA0 = 8'd11;
    REQ1 = 1'b1; ADDR1 = 3'd5; DATA1 = 8'd22;
    exp_q.push_back(mk(1, 3'd5, 8'd11, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 3'd5, 8'd22, 0, 1, 0, 0));
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(negedge CLK);
      if (ACK0) begin REQ0 = 1'b0; n++; end
      if (ACK1) begin REQ1 = 1'b0; n++; end
    end
    @(negedge CLK);
    checks++;
    if (rf_mem[5] !== 8'd22 || n != 2) begin
      errors++;
      $display("FAIL same_addr: got r5=%0d acks=%0d, want 22 2", rf_mem[5], n);
    end
  endtask

`ifdef RF_WRITE_PROTECT_EN
  task automatic test_write_protect();
    logic [7:0] before;
    @(negedge CLK);
    before = rf_mem[0];
    WPMASK = 8'h01;
    REQ1 = 1'b1; ADDR1 = 3'd0; DATA1 = 8'h99;
    exp_q.push_back(mk(0, 3'd0, 8'h99, 0, 1, 0, 1));
    @(negedge CLK);
    REQ1 = 1'b0;
    checks++;
    if (ACK1 !== 1'b1 || err1_w !== 1'b1 || RF_WRITE !== 1'b0) begin
      errors++;
      $display("FAIL wp_flags: got ack1=%0b err1=%0b wr=%0b, want 1 1 0", ACK1, err1_w, RF_WRITE);
    end
    @(negedge CLK);
    checks++;
    if (rf_mem[0] !== before || err1_w !== 1'b0) begin
      errors++;
      $display("FAIL wp_rf0: got r0=%h err1=%0b, want %h 0", rf_mem[0], err1_w, before);
    end
    WPMASK = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_clear();
    test_reset_mid_clear();
    test_same_addr();
`ifdef RF_WRITE_PROTECT_EN
    test_write_protect();
`endif
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
